// File: rtl/ufm_pkg.sv
// Shared constants and types for the UFM configuration writer.
// CSR map, CTRL/STATUS bit positions, FSM encoding, shift widths.
package ufm_pkg;

  localparam int AW = 9;
  localparam int DW = 16;

  localparam logic [4:0] OFF_HI = 5'd0;
  localparam logic [4:0] OFF_LO = 5'd1;
  localparam logic [4:0] OFF_CS = 5'd2;

  localparam int C_GO    = 0;
  localparam int C_ERASE = 1;
  localparam int C_PROG  = 2;
  localparam int C_CLR   = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_EREQ,
    ST_EWAIT,
    ST_DATA,
    ST_DEND,
    ST_PREQ,
    ST_PWAIT
  } state_t;

endpackage

// File: rtl/cfg_writer_altera_ufm_if.sv
// CSR bus between software and the UFM writer.
// master drives address/data/strobe, slave returns read data.
interface cfg_writer_altera_ufm_if;
  logic [4:0] csr_a;
  logic [7:0] csr_di;
  logic       csr_we;
  logic [7:0] csr_do;

  modport master (
    output csr_a,
    output csr_di,
    output csr_we,
    input  csr_do
  );

  modport slave (
    input  csr_a,
    input  csr_di,
    input  csr_we,
    output csr_do
  );
endinterface

// File: rtl/ufm_shift_out.sv
// N-bit MSB-first serializer, two clk cycles per bit.
// Data is set in the low phase, sclk rises in the high phase.
module ufm_shift_out #(
  parameter int N = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] data,
  output logic         sclk,
  output logic         sdat,
  output logic         last
);

  localparam int IW = $clog2(N);

  logic          run;
  logic [IW-1:0] idx;
  logic [N-1:0]  sh;

  // high phase of the final bit; the caller advances on this
  assign last = run & sclk & (idx == IW'(N - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      run  <= 1'b0;
      idx  <= '0;
      sh   <= '0;
      sclk <= 1'b0;
      sdat <= 1'b0;
    end else if (start) begin
      run  <= 1'b1;
      idx  <= '0;
      sh   <= {data[N-2:0], 1'b0};
      sclk <= 1'b0;
      sdat <= data[N-1];
    end else if (run) begin
      if (!sclk) begin
        sclk <= 1'b1;
      end else if (last) begin
        run  <= 1'b0;
        sclk <= 1'b0;
        sdat <= 1'b0;
      end else begin
        sclk <= 1'b0;
        sdat <= sh[N-1];
        sh   <= {sh[N-2:0], 1'b0};
        idx  <= idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cfg_writer_altera_ufm.sv
// UFM configuration word writer: CSR-loaded word, then address
// shift, optional erase, data shift and program with busy handshake.
module cfg_writer_altera_ufm
  import ufm_pkg::*;
#(
  parameter logic [4:0] BASE_ADDR  = 5'h3,
  parameter int         ACK_CYCLES = 16,
  parameter int         TIMEOUT_W  = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  cfg_writer_altera_ufm_if.slave csr,
  input  logic                   ufm_busy,
  output logic                   arclk,
  output logic                   ardin,
  output logic                   arshft,
  output logic                   drclk,
  output logic                   drdin,
  output logic                   drshft,
  output logic                   erase,
  output logic                   prog,
  output logic                   active
);

  localparam int ACW = $clog2(ACK_CYCLES + 1);
  localparam logic [ACW-1:0] ACK_LAST =
    ACW'(ACK_CYCLES - 1);
  localparam logic [TIMEOUT_W-1:0] TMO_LAST =
    {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  localparam logic [4:0] A_HI = BASE_ADDR + OFF_HI;
  localparam logic [4:0] A_LO = BASE_ADDR + OFF_LO;
  localparam logic [4:0] A_CS = BASE_ADDR + OFF_CS;

  state_t state_q, state_d;

  logic [DW-1:0]        word_q;
  logic [ACW-1:0]       ack_cnt;
  logic [TIMEOUT_W-1:0] wait_cnt;
  logic busy_q, en_e, en_p;
  logic error, done, tmo;
  logic set_err, set_tmo, set_done;
  logic sel_hi, sel_lo, sel_cs, wr_cs;
  logic go_acc, clr_err;
  logic a_start, a_last, d_start, d_last;

  assign sel_hi = csr.csr_a == A_HI;
  assign sel_lo = csr.csr_a == A_LO;
  assign sel_cs = csr.csr_a == A_CS;
  assign wr_cs  = csr.csr_we & sel_cs;

  assign clr_err = wr_cs & csr.csr_di[C_CLR];
  assign go_acc  = wr_cs & csr.csr_di[C_GO]
                 & (csr.csr_di[C_ERASE] | csr.csr_di[C_PROG])
                 & (state_q == ST_IDLE);

  assign a_start = go_acc;
  assign d_start = (state_d == ST_DATA)
                 & (state_q != ST_DATA);

  always_comb begin
    csr.csr_do = 8'h00;
    unique case (1'b1)
      sel_hi:  csr.csr_do = word_q[15:8];
      sel_lo:  csr.csr_do = word_q[7:0];
      sel_cs:  csr.csr_do = {active, error, done, 1'b0,
                             tmo, en_p, en_e, 1'b0};
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    set_err  = 1'b0;
    set_tmo  = 1'b0;
    set_done = 1'b0;
    unique case (state_q)
      ST_IDLE: if (go_acc) state_d = ST_ADDR;
      ST_ADDR:
        if (a_last) state_d = en_e ? ST_EREQ : ST_DATA;
      ST_EREQ:
        if (busy_q) begin
          state_d = ST_EWAIT;
        end else if (ack_cnt == ACK_LAST) begin
          set_err = 1'b1;
          state_d = ST_IDLE;
        end
      ST_EWAIT:
        if (!busy_q) begin
          if (en_p) begin
            state_d = ST_DATA;
          end else begin
            set_done = 1'b1;
            state_d  = ST_IDLE;
          end
        end else if (wait_cnt == TMO_LAST) begin
          set_err = 1'b1;
          set_tmo = 1'b1;
          state_d = ST_IDLE;
        end
      ST_DATA: if (d_last) state_d = ST_DEND;
      ST_DEND: state_d = ST_PREQ;
      ST_PREQ:
        if (busy_q) begin
          state_d = ST_PWAIT;
        end else if (ack_cnt == ACK_LAST) begin
          set_err = 1'b1;
          state_d = ST_IDLE;
        end
      ST_PWAIT:
        if (!busy_q) begin
          set_done = 1'b1;
          state_d  = ST_IDLE;
        end else if (wait_cnt == TMO_LAST) begin
          set_err = 1'b1;
          set_tmo = 1'b1;
          state_d = ST_IDLE;
        end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      busy_q   <= 1'b0;
      ack_cnt  <= '0;
      wait_cnt <= '0;
      word_q   <= 16'hFFFF;
      en_e     <= 1'b0;
      en_p     <= 1'b0;
      error    <= 1'b0;
      done     <= 1'b0;
      tmo      <= 1'b0;
      erase    <= 1'b0;
      prog     <= 1'b0;
      active   <= 1'b0;
      arshft   <= 1'b1;
      drshft   <= 1'b1;
    end else begin
      state_q <= state_d;
      busy_q  <= ufm_busy;
      // pin levels follow the state being entered
      erase   <= state_d == ST_EREQ;
      prog    <= state_d == ST_PREQ;
      active  <= state_d != ST_IDLE;
      arshft  <= 1'b1;
      drshft  <= state_d != ST_DEND;
      if (state_d != state_q) begin
        ack_cnt  <= '0;
        wait_cnt <= '0;
      end else begin
        ack_cnt  <= ack_cnt + 1'b1;
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (csr.csr_we && !active) begin
        if (sel_hi) word_q[15:8] <= csr.csr_di;
        if (sel_lo) word_q[7:0]  <= csr.csr_di;
      end
      if (go_acc) begin
        en_e <= csr.csr_di[C_ERASE];
        en_p <= csr.csr_di[C_PROG];
        done <= 1'b0;
      end
      if (set_done) done <= 1'b1;
      if (clr_err) begin
        error <= 1'b0;
        tmo   <= 1'b0;
      end
      if (set_err) error <= 1'b1;
      if (set_tmo) tmo <= 1'b1;
    end
  end

  ufm_shift_out #(.N(AW)) u_addr (
    .clk   (clk),
    .rst   (rst),
    .start (a_start),
    .data  ({AW{1'b0}}),
    .sclk  (arclk),
    .sdat  (ardin),
    .last  (a_last)
  );

  ufm_shift_out #(.N(DW)) u_data (
    .clk   (clk),
    .rst   (rst),
    .start (d_start),
    .data  (word_q),
    .sclk  (drclk),
    .sdat  (drdin),
    .last  (d_last)
  );

endmodule
